banked_spram_mem: RTL and testbench

Parametrised, word-addressed 32-bit memory built from NUM_BANKS independent SPRAM banks, each 16K x 32 (two SB_SPRAM256KA cells paired for width), replacing the fixed two-bank instruction memory. It adds a request/ready handshake, a registered read-bank select aligned to the one-cycle SPRAM read latency, and per-bank automatic standby with wake-up stalling. The block sits between the processor's memory interface and the SPRAM primitives.

---
 rtl/banked_mem_pkg.sv | 34 +++
 rtl/SB_SPRAM256KA.sv | 41 ++++
 rtl/spram_bank_ctrl.sv | 134 +++++++++++++
 rtl/banked_spram_mem.sv | 103 ++++++++++
 tb/tb_banked_spram_mem.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/banked_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : banked_mem_pkg
// Brief    : Shared types and constants for the banked SPRAM memory: bank
//            power-state encoding, geometry constants and the byte-enable to
//            SPRAM nibble-mask expansion.
// Revision : 1.0 - initial release
// ============================================================================
package banked_mem_pkg;

  localparam int c_bank_addr_w = 14;  // words per bank fixed by the SPRAM cell
  localparam int c_data_w      = 32;
  localparam int c_mask_w      = 4;

  // Bank power state; explicit encoding keeps the register width fixed.
  typedef enum logic [1:0] {
    AWAKE   = 2'd0,
    STANDBY = 2'd1,
    WAKING  = 2'd2
  } bank_state_e;

  // Each byte enable drives the two nibble write-enables covering that byte.
  function automatic logic [2*c_mask_w-1:0] expand_mask(input logic [c_mask_w-1:0] byte_en);
    logic [2*c_mask_w-1:0] nib;
    nib = '0;
    for (int i = 0; i < c_mask_w; i++) begin
      nib[2*i]   = byte_en[i];
      nib[2*i+1] = byte_en[i];
    end
    return nib;
  endfunction

endpackage
`default_nettype wire

// File: rtl/SB_SPRAM256KA.sv
`default_nettype none
// ============================================================================
// Module   : SB_SPRAM256KA
// Brief    : Behavioural model of the iCE40 UP 16K x 16 single-port RAM cell:
//            nibble-masked writes, registered read data, no access while in
//            standby/sleep or powered off.
// Revision : 1.0 - initial release
// ============================================================================
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] r_mem [16384];
  logic        w_active;

  assign w_active = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

  // Masked nibble write, or registered read; output holds otherwise.
  always_ff @(posedge CLOCK) begin
    if (w_active) begin
      if (WREN) begin
        for (int n = 0; n < 4; n++) begin
          if (MASKWREN[n]) r_mem[ADDRESS][4*n +: 4] <= DATAIN[4*n +: 4];
        end
      end else begin
        DATAOUT <= r_mem[ADDRESS];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spram_bank_ctrl
// Brief    : One 16K x 32 bank: two paired SPRAM cells plus, when
//            BANKED_MEM_AUTO_STANDBY_EN is defined, the idle/standby/wake FSM
//            that drives the cells' STANDBY pin and the bank awake status.
// Revision : 1.0 - initial release
// ============================================================================
module spram_bank_ctrl
  import banked_mem_pkg::*;
#(
  parameter int BANK_ADDR_W = c_bank_addr_w,
  parameter int IDLE_CYCLES = 256,
  parameter int WAKE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,        // access accepted for this bank
  input  logic                    req_hit,   // request targets this bank
  input  logic                    we,
  input  logic [BANK_ADDR_W-1:0]  addr,
  input  logic [c_data_w-1:0]     wdata,
  input  logic [2*c_mask_w-1:0]   nibble_mask,
  output logic [c_data_w-1:0]     rdata,
  output logic                    awake
);

  logic w_standby;
  logic w_wren;

  assign w_wren = cs & we;

`ifdef BANKED_MEM_AUTO_STANDBY_EN
  localparam int c_idle_w = $clog2(IDLE_CYCLES);
  localparam int c_wake_w = $clog2(WAKE_CYCLES + 1);
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_CYCLES - 1);
  localparam logic [c_wake_w-1:0] c_wake_load = c_wake_w'(WAKE_CYCLES - 1);

  bank_state_e         r_state, w_state_nxt;
  logic [c_idle_w-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [c_wake_w-1:0] r_wake_cnt, w_wake_cnt_nxt;

  // Power-state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= AWAKE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
    end
  end

  // Idle timeout into standby, wake on a request, fixed wake-up delay.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    case (r_state)
      AWAKE: begin
        // An access in the expiring cycle wins over the timeout.
        if (cs) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == c_idle_last) begin
          w_state_nxt    = STANDBY;
          w_idle_cnt_nxt = '0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      STANDBY: begin
        if (req_hit) begin
          w_state_nxt    = WAKING;
          w_wake_cnt_nxt = c_wake_load;
        end
      end
      WAKING: begin
        if (r_wake_cnt == '0) begin
          w_state_nxt    = AWAKE;
          w_idle_cnt_nxt = '0;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt    = AWAKE;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

  assign w_standby = (r_state == STANDBY);
  assign awake     = (r_state == AWAKE);
`else
  // Power management absent: cells always active, bank always usable.
  localparam int c_unused_cfg = IDLE_CYCLES + WAKE_CYCLES;
  logic w_unused;
  assign w_unused  = ^{rst_n, req_hit};
  assign w_standby = 1'b0;
  assign awake     = 1'b1;
`endif

  // Low half-word cell.
  SB_SPRAM256KA u_spram_lo (
    .ADDRESS    (addr),
    .DATAIN     (wdata[15:0]),
    .MASKWREN   (nibble_mask[3:0]),
    .WREN       (w_wren),
    .CHIPSELECT (cs),
    .CLOCK      (clk),
    .STANDBY    (w_standby),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata[15:0])
  );

  // High half-word cell.
  SB_SPRAM256KA u_spram_hi (
    .ADDRESS    (addr),
    .DATAIN     (wdata[31:16]),
    .MASKWREN   (nibble_mask[7:4]),
    .WREN       (w_wren),
    .CHIPSELECT (cs),
    .CLOCK      (clk),
    .STANDBY    (w_standby),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (rdata[31:16])
  );

endmodule
`default_nettype wire

// File: rtl/banked_spram_mem.sv
`default_nettype none
// ============================================================================
// Module   : banked_spram_mem
// Brief    : Word-addressed 32-bit memory of NUM_BANKS SPRAM banks with a
//            req/ready handshake, one-cycle read return and optional per-bank
//            auto-standby (BANKED_MEM_AUTO_STANDBY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module banked_spram_mem
  import banked_mem_pkg::*;
#(
  parameter int NUM_BANKS   = 2,
  parameter int BANK_ADDR_W = c_bank_addr_w,
  parameter int ADDR_W      = BANK_ADDR_W + $clog2(NUM_BANKS),
  parameter int IDLE_CYCLES = 256,
  parameter int WAKE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [c_data_w-1:0]   wdata,
  input  logic [c_mask_w-1:0]   wmask,
  output logic                  ready,
  output logic                  rvalid,
  output logic [c_data_w-1:0]   rdata,
  output logic [NUM_BANKS-1:0]  bank_awake
);

  localparam int c_sel_w = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [c_sel_w-1:0]      w_bank_sel;
  logic [NUM_BANKS-1:0]    w_awake;
  logic [NUM_BANKS-1:0]    w_cs;
  logic [NUM_BANKS-1:0]    w_req_hit;
  logic [c_data_w-1:0]     w_bank_rdata [NUM_BANKS];
  logic [2*c_mask_w-1:0]   w_nibble_mask;
  logic                    w_accept;
  logic                    r_rvalid;
  logic [c_sel_w-1:0]      r_rd_sel;
  logic [c_data_w-1:0]     r_rdata_hold;

  generate
    if (NUM_BANKS > 1) begin : g_sel_multi
      assign w_bank_sel = addr[ADDR_W-1:BANK_ADDR_W];
    end else begin : g_sel_single
      assign w_bank_sel = '0;
    end
  endgenerate

  // Ready only depends on the target bank, so a waking bank never stalls others.
  assign ready         = rst_n & w_awake[w_bank_sel];
  assign w_accept      = req & ready;
  assign w_nibble_mask = expand_mask(wmask);
  assign bank_awake    = w_awake;

  generate
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
      assign w_cs[i]      = w_accept & (w_bank_sel == c_sel_w'(i));
      assign w_req_hit[i] = req & (w_bank_sel == c_sel_w'(i));

      spram_bank_ctrl #(
        .BANK_ADDR_W (BANK_ADDR_W),
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES)
      ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (w_cs[i]),
        .req_hit     (w_req_hit[i]),
        .we          (we),
        .addr        (addr[BANK_ADDR_W-1:0]),
        .wdata       (wdata),
        .nibble_mask (w_nibble_mask),
        .rdata       (w_bank_rdata[i]),
        .awake       (w_awake[i])
      );
    end
  endgenerate

  // Track an accepted read and remember which bank returns its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rd_sel <= '0;
    end else begin
      r_rvalid <= w_accept & ~we;
      if (w_accept & ~we) r_rd_sel <= w_bank_sel;
    end
  end

  // Capture returned data so rdata holds between reads even if cells change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rdata_hold <= '0;
    else if (r_rvalid) r_rdata_hold <= w_bank_rdata[r_rd_sel];
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rvalid ? w_bank_rdata[r_rd_sel] : r_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_banked_spram_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_spram_mem
// Brief    : Directed self-checking bench for banked_spram_mem with a read
//            scoreboard (IDLE_CYCLES = 4, WAKE_CYCLES = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_spram_mem;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        req    = 1'b0;
  logic        we     = 1'b0;
  logic [14:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [3:0]  wmask  = '0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  bank_awake;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  logic        acc_rd = 1'b0;
  logic        exp_rv;
  logic        chk_en = 1'b0;
  logic [31:0] sb_q [$];

  banked_spram_mem #(
    .NUM_BANKS   (2),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .wmask      (wmask),
    .ready      (ready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .bank_awake (bank_awake)
  );

  always #5 clk = ~clk;

  // rvalid must follow a read acceptance by exactly one edge; reset kills it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_rv <= 1'b0;
    else        exp_rv <= acc_rd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: timing of rvalid every cycle, data from scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rvalid_timing", {31'd0, rvalid}, {31'd0, exp_rv});
      if (rvalid && exp_rv && sb_q.size() > 0) check("rdata", rdata, sb_q.pop_front());
    end
  end

  task automatic do_access(input logic w, input logic [14:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [31:0] exp_rd, output int waits);
    req = 1'b1; we = w; addr = a; wdata = d; wmask = m; waits = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waits < 32) begin
      waits++;
      @(negedge clk);
    end
    if (ready !== 1'b1) begin
      check("ready_timeout", {31'd0, ready}, 32'd1);
      req = 1'b0;
    end else begin
      if (!w) begin
        sb_q.push_back(exp_rd);
        acc_rd = 1'b1;
      end
      @(posedge clk);
      #1;
      acc_rd = 1'b0;
      req    = 1'b0;
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] m);
    int w;
    do_access(1'b1, a, d, m, 32'h0, w);
  endtask

  // exp_waits < 0: stall count not checked for this read.
  task automatic rd(input logic [14:0] a, input logic [31:0] exp, input int exp_waits);
    int w;
    do_access(1'b0, a, 32'h0, 4'h0, exp, w);
    if (exp_waits >= 0) check("ready_stall_cycles", w, exp_waits);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_ready",  {31'd0, ready},  32'd0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    check("reset_rdata",  rdata,           32'd0);
    check("reset_awake",  {30'd0, bank_awake}, 32'd3);
    chk_en = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic write/read in both banks.
    wr(15'h0000, 32'hDEADBEEF, 4'hF);
    wr(15'h4000, 32'hCAFEF00D, 4'hF);
    rd(15'h0000, 32'hDEADBEEF, -1);
    rd(15'h4000, 32'hCAFEF00D, -1);

    // Byte-masked write, zero-mask write, rdata held across writes.
    wr(15'h0010, 32'h11223344, 4'hF);
    check("rdata_hold", rdata, 32'hCAFEF00D);
    wr(15'h0010, 32'hAABBCCDD, 4'h5);
    wr(15'h0010, 32'hFFFFFFFF, 4'h0);
    rd(15'h0010, 32'h11BB33DD, -1);

    // Back-to-back reads alternating banks: no stalls, one return per cycle.
    wr(15'h4001, 32'hB0000001, 4'hF);
    wr(15'h0001, 32'hA0000001, 4'hF);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) rd(15'h4001, 32'hB0000001, 0);
      else            rd(15'h0001, 32'hA0000001, 0);
    end

`ifdef BANKED_MEM_AUTO_STANDBY_EN
    // Bank 1 idle for 3 cycles still awake, for 4 cycles in standby.
    repeat (3) rd(15'h0000, 32'hDEADBEEF, 0);
    check("awake_idle3", {30'd0, bank_awake}, 32'd3);
    rd(15'h0000, 32'hDEADBEEF, 0);
    check("standby_idle4", {30'd0, bank_awake}, 32'd1);

    // Standby bank: ready low WAKE_CYCLES+1 cycles, then accepted.
    rd(15'h4000, 32'hCAFEF00D, 4);

    // Bank 0 keeps running while bank 1 wakes.
    repeat (4) rd(15'h0000, 32'hDEADBEEF, 0);
    check("standby_again", {30'd0, bank_awake}, 32'd1);
    req = 1'b1; we = 1'b0; addr = 15'h4000;
    @(negedge clk);
    check("ready_standby", {31'd0, ready}, 32'd0);
    @(posedge clk); #1; req = 1'b0;
    rd(15'h0000, 32'hDEADBEEF, 0);
    rd(15'h0000, 32'hDEADBEEF, 0);
    check("waking_status", {30'd0, bank_awake}, 32'd1);
    rd(15'h4000, 32'hCAFEF00D, 1);

    // Access bank 0 in the cycle its idle counter expires.
    rd(15'h0000, 32'hDEADBEEF, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bank0_cnt3_awake", {31'd0, bank_awake[0]}, 32'd1);
    rd(15'h0000, 32'hDEADBEEF, 0);
    check("bank0_expiry_access", {31'd0, bank_awake[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bank0_cleared_cnt", {31'd0, bank_awake[0]}, 32'd1);
    @(posedge clk); #1;
    check("bank0_standby", {31'd0, bank_awake[0]}, 32'd0);
`else
    // Without power management banks stay awake and never stall.
    repeat (10) @(posedge clk);
    #1;
    check("always_awake", {30'd0, bank_awake}, 32'd3);
    rd(15'h4000, 32'hCAFEF00D, 0);
    rd(15'h0000, 32'hDEADBEEF, 0);
`endif

    // Reset right after a read is accepted: no rvalid, state back to reset.
    rd(15'h0010, 32'h11BB33DD, -1);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata",  rdata,           32'd0);
    check("rst_ready",  {31'd0, ready},  32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awake", {30'd0, bank_awake}, 32'd3);
    check("post_rst_rdata", rdata, 32'd0);
`ifdef BANKED_MEM_AUTO_STANDBY_EN
    // Counters restarted from zero: standby after exactly IDLE_CYCLES edges.
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle3", {30'd0, bank_awake}, 32'd3);
    @(posedge clk); #1;
    check("post_rst_idle4", {30'd0, bank_awake}, 32'd0);
`endif

    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
